// File: rtl/id_stage_pkg.sv
// mips_defs: shared decode constants for the MIPS decode stage.
//   - opcode / funct encodings for the supported instruction subset
//   - exe_cmd_e: ALU command encoding carried into execute (NOP = 0)
//   - NOP_INSTR: the all-zero instruction written into squashed slots
//   - REG_IDX_W: architectural register index width
package mips_defs;

    localparam int REG_IDX_W = 5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    typedef enum logic [3:0] {
        EXE_NOP = 4'd0,
        EXE_ADD = 4'd1,
        EXE_SUB = 4'd2,
        EXE_AND = 4'd3,
        EXE_OR  = 4'd4,
        EXE_SLT = 4'd5
    } exe_cmd_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/id_stage_register_file.sv
// Register_file: REG_COUNT x WIDTH architectural registers.
//   clk, rst (async active-low, clears every register)
//   rd_addr1/rd_data1, rd_addr2/rd_data2 : asynchronous read ports
//   wr_en, wr_addr, wr_data              : synchronous write port
// Register 0 always reads 0 and ignores writes.
// Build option ID_WB_BYPASS_EN: a read of the register being written this
// cycle returns wr_data instead of the stored (old) value.
module Register_file
    import mips_defs::*;
#(
    parameter int WIDTH     = 32,
    parameter int REG_COUNT = 32,
    parameter int AW        = $clog2(REG_COUNT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    rd_addr1,
    input  logic [AW-1:0]    rd_addr2,
    output logic [WIDTH-1:0] rd_data1,
    output logic [WIDTH-1:0] rd_data2,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data
);

    logic [WIDTH-1:0] regs [REG_COUNT];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
        end else if (wr_en && (wr_addr != '0)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data1 = (rd_addr1 == '0) ? '0 : regs[rd_addr1];
        rd_data2 = (rd_addr2 == '0) ? '0 : regs[rd_addr2];
`ifdef ID_WB_BYPASS_EN
        if (wr_en && (wr_addr != '0) && (wr_addr == rd_addr1)) rd_data1 = wr_data;
        if (wr_en && (wr_addr != '0) && (wr_addr == rd_addr2)) rd_data2 = wr_data;
`endif
    end

endmodule

// File: rtl/id_stage.sv
// id_stage: MIPS instruction-decode stage.
//   Inputs : clk, rst (async active-low), PC_in/instruction_in from fetch,
//            WB_en/WB_dest/WB_value from write-back.
//   Outputs: Br_taken/Br_offset (combinational redirect to fetch), and the
//            registered ID/EX latch: PC_out, val1, val2, imm_ext, dest,
//            src1, src2, EXE_cmd, MEM_R_en, MEM_W_en, WB_en_out, valid_out.
// Build option ID_WB_BYPASS_EN (handled inside Register_file): same-cycle
// write-back data is forwarded to operand reads and the branch compare.
module id_stage
    import mips_defs::*;
#(
    parameter int WIDTH     = 32,
    parameter int REG_COUNT = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [31:0]                  PC_in,
    input  logic [31:0]                  instruction_in,
    input  logic                         WB_en,
    input  logic [$clog2(REG_COUNT)-1:0] WB_dest,
    input  logic [WIDTH-1:0]             WB_value,
    output logic                         Br_taken,
    output logic [15:0]                  Br_offset,
    output logic [31:0]                  PC_out,
    output logic [WIDTH-1:0]             val1,
    output logic [WIDTH-1:0]             val2,
    output logic [WIDTH-1:0]             imm_ext,
    output logic [$clog2(REG_COUNT)-1:0] dest,
    output logic [$clog2(REG_COUNT)-1:0] src1,
    output logic [$clog2(REG_COUNT)-1:0] src2,
    output logic [3:0]                   EXE_cmd,
    output logic                         MEM_R_en,
    output logic                         MEM_W_en,
    output logic                         WB_en_out,
    output logic                         valid_out
);

    localparam int AW = $clog2(REG_COUNT);

    logic             if_valid;
    logic [31:0]      if_pc;
    logic [31:0]      if_instr;

    logic [5:0]       op;
    logic [5:0]       funct;
    logic [AW-1:0]    rs, rt, rd;
    logic [WIDTH-1:0] rs_val, rt_val, imm_val;

    exe_cmd_e         d_cmd;
    logic             d_mem_r, d_mem_w, d_wb;
    logic [AW-1:0]    d_dest;
    logic             is_beq, is_bne;

    assign op      = if_instr[31:26];
    assign funct   = if_instr[5:0];
    assign rs      = if_instr[21 +: AW];
    assign rt      = if_instr[16 +: AW];
    assign rd      = if_instr[11 +: AW];
    assign imm_val = {{(WIDTH-16){if_instr[15]}}, if_instr[15:0]};

    Register_file #(.WIDTH(WIDTH), .REG_COUNT(REG_COUNT)) u_rf (
        .clk      (clk),
        .rst      (rst),
        .rd_addr1 (rs),
        .rd_addr2 (rt),
        .rd_data1 (rs_val),
        .rd_data2 (rt_val),
        .wr_en    (WB_en),
        .wr_addr  (WB_dest),
        .wr_data  (WB_value)
    );

    // A taken branch turns the instruction fetched behind it into a bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_valid <= 1'b0;
            if_pc    <= '0;
            if_instr <= NOP_INSTR;
        end else if (Br_taken) begin
            if_valid <= 1'b0;
            if_pc    <= PC_in;
            if_instr <= NOP_INSTR;
        end else begin
            if_valid <= 1'b1;
            if_pc    <= PC_in;
            if_instr <= instruction_in;
        end
    end

    // Invalid slots and unsupported encodings fall through as NOP.
    always_comb begin
        d_cmd   = EXE_NOP;
        d_mem_r = 1'b0;
        d_mem_w = 1'b0;
        d_wb    = 1'b0;
        d_dest  = '0;
        is_beq  = 1'b0;
        is_bne  = 1'b0;
        if (if_valid) begin
            case (op)
                OP_RTYPE: begin
                    case (funct)
                        FN_ADD:  begin d_cmd = EXE_ADD; d_wb = 1'b1; d_dest = rd; end
                        FN_SUB:  begin d_cmd = EXE_SUB; d_wb = 1'b1; d_dest = rd; end
                        FN_AND:  begin d_cmd = EXE_AND; d_wb = 1'b1; d_dest = rd; end
                        FN_OR:   begin d_cmd = EXE_OR;  d_wb = 1'b1; d_dest = rd; end
                        FN_SLT:  begin d_cmd = EXE_SLT; d_wb = 1'b1; d_dest = rd; end
                        default: ;
                    endcase
                end
                OP_ADDI: begin d_cmd = EXE_ADD; d_wb = 1'b1; d_dest = rt; end
                OP_LW:   begin d_cmd = EXE_ADD; d_wb = 1'b1; d_mem_r = 1'b1; d_dest = rt; end
                OP_SW:   begin d_cmd = EXE_ADD; d_mem_w = 1'b1; end
                OP_BEQ:  is_beq = 1'b1;
                OP_BNE:  is_bne = 1'b1;
                default: ;
            endcase
        end
    end

    // Offset is relative to fetch's current PC (branch PC + 4); only
    // imm[13:0] fits in 16 bits after the word shift.
    assign Br_taken  = (is_beq && (rs_val == rt_val)) || (is_bne && (rs_val != rt_val));
    assign Br_offset = Br_taken ? {if_instr[13:0], 2'b00} : 16'h0000;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            PC_out    <= '0;
            val1      <= '0;
            val2      <= '0;
            imm_ext   <= '0;
            dest      <= '0;
            src1      <= '0;
            src2      <= '0;
            EXE_cmd   <= EXE_NOP;
            MEM_R_en  <= 1'b0;
            MEM_W_en  <= 1'b0;
            WB_en_out <= 1'b0;
            valid_out <= 1'b0;
        end else begin
            PC_out    <= if_pc;
            val1      <= rs_val;
            val2      <= rt_val;
            imm_ext   <= imm_val;
            dest      <= d_dest;
            src1      <= rs;
            src2      <= rt;
            EXE_cmd   <= d_cmd;
            MEM_R_en  <= d_mem_r;
            MEM_W_en  <= d_mem_w;
            WB_en_out <= d_wb;
            valid_out <= if_valid;
        end
    end

endmodule

// File: tb/tb_id_stage.sv
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PC_in;
    logic [31:0] instruction_in;
    logic        WB_en;
    logic [4:0]  WB_dest;
    logic [31:0] WB_value;
    logic        Br_taken;
    logic [15:0] Br_offset;
    logic [31:0] PC_out, val1, val2, imm_ext;
    logic [4:0]  dest, src1, src2;
    logic [3:0]  EXE_cmd;
    logic        MEM_R_en, MEM_W_en, WB_en_out, valid_out;

    int n_pass  = 0;
    int n_total = 0;

    id_stage dut (
        .clk            (clk),
        .rst            (rst),
        .PC_in          (PC_in),
        .instruction_in (instruction_in),
        .WB_en          (WB_en),
        .WB_dest        (WB_dest),
        .WB_value       (WB_value),
        .Br_taken       (Br_taken),
        .Br_offset      (Br_offset),
        .PC_out         (PC_out),
        .val1           (val1),
        .val2           (val2),
        .imm_ext        (imm_ext),
        .dest           (dest),
        .src1           (src1),
        .src2           (src2),
        .EXE_cmd        (EXE_cmd),
        .MEM_R_en       (MEM_R_en),
        .MEM_W_en       (MEM_W_en),
        .WB_en_out      (WB_en_out),
        .valid_out      (valid_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rtype(input logic [4:0] rd, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] pc, input logic [31:0] ins);
        PC_in = pc;
        instruction_in = ins;
        tick();
    endtask

    task automatic wb(input logic [4:0] r, input logic [31:0] v);
        WB_en = 1'b1;
        WB_dest = r;
        WB_value = v;
        tick();
        WB_en = 1'b0;
    endtask

    initial begin
        // reset with random inputs, including a BEQ that would be taken
        rst = 1'b0;
        PC_in = $urandom;
        instruction_in = {6'h04, 10'd0, 16'h0003};
        WB_en = 1'b1;
        WB_dest = 5'd1;
        WB_value = $urandom;
        repeat (3) tick();
        chk("rst_PC_out", PC_out, 32'h0);
        chk("rst_val1", val1, 32'h0);
        chk("rst_val2", val2, 32'h0);
        chk("rst_imm", imm_ext, 32'h0);
        chk("rst_dest_src", {17'd0, dest, src1, src2}, 32'h0);
        chk("rst_cmd", {28'd0, EXE_cmd}, 32'h0);
        chk("rst_ctrl", {28'd0, MEM_R_en, MEM_W_en, WB_en_out, valid_out}, 32'h0);
        chk("rst_br", {15'd0, Br_taken, Br_offset}, 32'h0);

        // release, ADD r3,r1,r2 at PC 0
        WB_en = 1'b0;
        PC_in = 32'h0;
        instruction_in = rtype(5'd3, 5'd1, 5'd2, 6'h20);
        rst = 1'b1;
        tick();
        issue(32'h4, 32'h0);
        chk("first_cmd", {28'd0, EXE_cmd}, 32'd1);
        chk("first_dest", {27'd0, dest}, 32'd3);
        chk("first_valid", {31'd0, valid_out}, 32'd1);
        chk("first_pc", PC_out, 32'h0);
        chk("first_val1", val1, 32'h0);

        // write-back and r0
        instruction_in = 32'h0;
        wb(5'd1, 32'd5);
        wb(5'd2, 32'd7);
        wb(5'd0, 32'd9);
        issue(32'h08, rtype(5'd3, 5'd1, 5'd2, 6'h20));
        issue(32'h0C, rtype(5'd7, 5'd0, 5'd2, 6'h20));
        chk("wb_val1", val1, 32'd5);
        chk("wb_val2", val2, 32'd7);
        chk("wb_src", {22'd0, src1, src2}, {22'd0, 5'd1, 5'd2});
        issue(32'h0C, 32'h0);
        chk("r0_val1", val1, 32'd0);
        chk("r0_dest", {27'd0, dest}, 32'd7);

        // taken BEQ r1,r1,+3 at 0x10, followed by another taken-looking BEQ
        issue(32'h10, itype(6'h04, 5'd1, 5'd1, 16'd3));
        chk("beq_taken", {31'd0, Br_taken}, 32'd1);
        chk("beq_offset", {16'd0, Br_offset}, 32'h0000_000C);
        issue(32'h14, itype(6'h04, 5'd1, 5'd1, 16'd5));
        chk("beq2_not_taken", {15'd0, Br_taken, Br_offset}, 32'h0);
        chk("beq_idex_valid", {31'd0, valid_out}, 32'd1);
        chk("beq_idex_nop", {27'd0, EXE_cmd, WB_en_out}, 32'h0);
        chk("beq_idex_pc", PC_out, 32'h10);
        issue(32'h20, itype(6'h05, 5'd1, 5'd1, 16'd3));
        chk("squash_valid", {31'd0, valid_out}, 32'd0);

        // not-taken BNE r1,r1,+3 at 0x20
        chk("bne_not_taken", {15'd0, Br_taken, Br_offset}, 32'h0);
        issue(32'h24, rtype(5'd3, 5'd1, 5'd2, 6'h20));
        issue(32'h28, 32'h0);
        chk("bne_next_valid", {31'd0, valid_out}, 32'd1);
        chk("bne_next_cmd", {28'd0, EXE_cmd}, 32'd1);
        chk("bne_next_pc", PC_out, 32'h24);

        // same-cycle write-back and read of r4
        instruction_in = 32'h0;
        wb(5'd4, 32'h11);
        issue(32'h30, rtype(5'd5, 5'd4, 5'd0, 6'h20));
        instruction_in = 32'h0;
        wb(5'd4, 32'hAA);
`ifdef ID_WB_BYPASS_EN
        chk("bypass_val1", val1, 32'hAA);
`else
        chk("bypass_val1", val1, 32'h11);
`endif
        chk("bypass_dest", {27'd0, dest}, 32'd5);
        issue(32'h34, rtype(5'd5, 5'd4, 5'd0, 6'h20));
        issue(32'h38, 32'h0);
        chk("r4_after_wb", val1, 32'hAA);

        // decode coverage
        issue(32'h40, itype(6'h23, 5'd1, 5'd6, 16'hFFFC));
        issue(32'h44, itype(6'h2B, 5'd1, 5'd2, 16'h0008));
        chk("lw_ctrl", {28'd0, MEM_R_en, MEM_W_en, WB_en_out, valid_out}, 32'b1011);
        chk("lw_dest", {27'd0, dest}, 32'd6);
        chk("lw_imm", imm_ext, 32'hFFFF_FFFC);
        chk("lw_val1", val1, 32'd5);
        issue(32'h48, 32'hFC00_0000);
        chk("sw_ctrl", {28'd0, MEM_R_en, MEM_W_en, WB_en_out, valid_out}, 32'b0101);
        chk("sw_dest", {27'd0, dest}, 32'd0);
        chk("sw_val2", val2, 32'd7);
        issue(32'h4C, rtype(5'd8, 5'd2, 5'd1, 6'h22));
        chk("unk_ctrl", {28'd0, MEM_R_en, MEM_W_en, WB_en_out, valid_out}, 32'b0001);
        chk("unk_cmd", {28'd0, EXE_cmd}, 32'd0);
        issue(32'h50, itype(6'h08, 5'd1, 5'd9, 16'hFFFF));
        chk("sub_cmd", {28'd0, EXE_cmd}, 32'd2);
        chk("sub_vals", {val1[15:0], val2[15:0]}, {16'd7, 16'd5});
        chk("sub_dest", {27'd0, dest}, 32'd8);
        issue(32'h54, rtype(5'd10, 5'd1, 5'd2, 6'h2A));
        chk("addi_cmd_wb", {27'd0, EXE_cmd, WB_en_out}, {27'd0, 4'd1, 1'b1});
        chk("addi_dest", {27'd0, dest}, 32'd9);
        chk("addi_imm", imm_ext, 32'hFFFF_FFFF);
        issue(32'h58, 32'h0);
        chk("slt_cmd", {28'd0, EXE_cmd}, 32'd5);
        chk("slt_dest", {27'd0, dest}, 32'd10);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
